ls_mem_responder: RTL and testbench
===================================

# ls_mem_responder

Memory-side responder for the DTPU load/store path: accepts burst load and store requests from the load/store unit and drives a single-port on-chip BRAM (weights/activations). Load bursts are streamed back with valid/ready backpressure, absorbing the BRAM's fixed read latency in a credit-controlled return FIFO. Store bursts are written one beat per accepted data handshake.

## Interface
- data_width, 64, data beat width
- addr_width, 10, BRAM word address width
- rd_latency, 2, BRAM read latency in cycles (≥1)
- clk  in  1  clock, all logic on rising edge
- resetn  in  1  asynchronous active-low reset
- req_valid / req_ready  in / out  1  request handshake
- req_write  in  1  1 = store burst, 0 = load burst
- req_addr  in  addr_width  first word address
- req_len  in  4  beats minus one (0 → 1 beat, 15 → 16 beats)
- wr_valid / wr_ready  in / out  1  store data handshake
- wr_data  in  data_width  store beat
- rd_valid / rd_ready  out / in  1  load data handshake
- rd_data  out  data_width  load beat
- rd_last  out  1  marks final beat of a load burst
- busy  out  1  burst in progress or read data outstanding
- mem_en, mem_we  out  1  BRAM enable / write enable
- mem_addr  out  addr_width  BRAM address
- mem_wdata  out  data_width  BRAM write data
- mem_rdata  in  data_width  BRAM read data, valid rd_latency cycles after mem_en & !mem_we

## Operation
- FSM states: IDLE, READ, WRITE. req_ready = 1 only in IDLE (and not in reset).
- IDLE: on req_valid & req_ready latch addr, len, direction; go READ or WRITE.
- READ: issue one BRAM read per cycle while credit available; credit = (rd_latency+2) − FIFO occupancy − reads in flight. Each issued read carries a last tag through a rd_latency-deep tag pipe. After issuing final beat → IDLE; in-flight data continues to drain.
- WRITE: wr_ready = 1; each wr_valid & wr_ready writes one beat, address +1. After final beat → IDLE. wr_ready = 0 outside WRITE; wr_valid ignored there.
- Address increments modulo 2^addr_width (burst wraps from max to 0).
- Return FIFO: depth rd_latency+2, written from mem_rdata + tag; head presented on rd_data/rd_last/rd_valid; pops on rd_valid & rd_ready. Never overflows by credit rule.
- busy = state ≠ IDLE | reads in flight | FIFO non-empty.
- A new request may be accepted while prior load data drains; ordering preserved (BRAM in-order).
- Reset (any time, incl. mid-burst): FSM → IDLE, burst aborted, tag pipe and FIFO flushed.
- Reset values: req_ready 0 while resetn low then 1; wr_ready, rd_valid, rd_last, busy, mem_en, mem_we 0; mem_addr, mem_wdata, rd_data 0.

## Timing
- All outputs registered except rd_* (driven from FIFO head registers) and the ready signals (decoded from state).
- Request accepted cycle T → first mem_en in T+1; with rd_ready high, first rd_valid in T+2+rd_latency; one beat per cycle thereafter (full throughput).
- rd_ready low stalls issue once credit is exhausted; no beat lost or duplicated.
- Store handshake in cycle W → mem_en & mem_we with that address/data in W+1.
- Earliest next request accepted the cycle after final beat issued/written.

## Configuration
- LS_MEM_RESP_BYTE_WE_EN defined: adds input wr_strb (data_width/8 bits) paired with wr_data; mem_we becomes data_width/8 bits, equal to the strobe on writes, all-zero on reads.
- Undefined: no wr_strb; mem_we is 1 bit, full-word writes.

## Structure
- Package ls_mem_resp_pkg: FSM state enum, LEN_W = 4 constant, function returning FIFO depth from rd_latency.
- One sub-module: ls_mem_resp_fifo (synchronous FIFO, data+last, parameterised width/depth, async active-low reset).

## Test plan
- Load req addr 0x010 len 3, rd_ready high, rd_latency 2 → mem_addr 0x010..0x013 in T+1..T+4, rd_valid T+4..T+7, rd_last on 4th beat only.
- Store req addr 0x3FE len 3, data A,B,C,D → writes at 0x3FE, 0x3FF, 0x000, 0x001 (wrap), then IDLE.
- Load len 15 with rd_ready toggling 1-of-3 cycles → 16 beats in address order, FIFO never exceeds 4 entries, no loss.
- Load len 7 then store immediately after last issue → store accepted while reads drain; read data is pre-store content.
- resetn low mid-load (beat 3 of 8) → rd_valid, mem_en, busy 0 immediately; after release req_ready 1, next load returns correct data with no stale beats.
- With LS_MEM_RESP_BYTE_WE_EN, store wr_strb 0x0F → mem_we 0x0F; reads show mem_we 0x00.

Source files
------------

// File: rtl/ls_mem_resp_pkg.sv
// ---------------------------------------------------------------------------
// ls_mem_resp_pkg
// Shared types and constants for the load/store memory responder.
//   state_e     : responder FSM encoding (IDLE / READ / WRITE)
//   LEN_W       : width of the burst-length field (beats minus one)
//   fifo_depth  : return FIFO depth needed to absorb a given BRAM read latency
// ---------------------------------------------------------------------------
package ls_mem_resp_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READ  = 2'd1,
      ST_WRITE = 2'd2
   } state_e;

   localparam int LEN_W = 4;

   // Latency slots plus one beat being popped plus one beat being issued.
   function automatic int fifo_depth(input int rd_lat);
      return rd_lat + 2;
   endfunction

endpackage

// File: rtl/ls_mem_resp_fifo.sv
// ---------------------------------------------------------------------------
// ls_mem_resp_fifo
// Small synchronous FIFO holding returned load beats (data + last tag).
// Ports:
//   clk, resetn   clock, asynchronous active-low reset (flushes contents)
//   push, din     write one entry (ignored when full)
//   pop           remove head entry (ignored when empty)
//   valid, dout   head entry present / head entry (zero when empty)
//   count         current occupancy
// ---------------------------------------------------------------------------
module ls_mem_resp_fifo #(
   parameter int width = 65,
   parameter int depth = 4
) (
   input  logic                         clk,
   input  logic                         resetn,
   input  logic                         push,
   input  logic [width-1:0]             din,
   input  logic                         pop,
   output logic                         valid,
   output logic [width-1:0]             dout,
   output logic [$clog2(depth+1)-1:0]   count
);

   localparam int PTR_W = (depth > 1) ? $clog2(depth) : 1;
   localparam int CNT_W = $clog2(depth + 1);

   logic [width-1:0] r_mem [depth];
   logic [PTR_W-1:0] r_wptr;
   logic [PTR_W-1:0] r_rptr;
   logic [CNT_W-1:0] r_count;
   logic             w_push;
   logic             w_pop;

   // Depth need not be a power of two, so pointers wrap explicitly.
   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(depth - 1)) ? PTR_W'(0) : p + PTR_W'(1);
   endfunction

   assign w_push = push & (r_count != CNT_W'(depth));
   assign w_pop  = pop & (r_count != CNT_W'(0));
   assign valid  = (r_count != CNT_W'(0));
   assign dout   = valid ? r_mem[r_rptr] : {width{1'b0}};
   assign count  = r_count;

   // Storage, pointers and occupancy.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         for (int i = 0; i < depth; i++) begin
            r_mem[i] <= {width{1'b0}};
         end
         r_wptr  <= PTR_W'(0);
         r_rptr  <= PTR_W'(0);
         r_count <= CNT_W'(0);
      end else begin
         if (w_push) begin
            r_mem[r_wptr] <= din;
            r_wptr        <= ptr_inc(r_wptr);
         end
         if (w_pop) begin
            r_rptr <= ptr_inc(r_rptr);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/ls_mem_responder.sv
// ---------------------------------------------------------------------------
// ls_mem_responder
// Memory-side responder for the load/store path. Accepts burst load/store
// requests and drives a single-port BRAM with fixed read latency. Load data
// returns through a credit-controlled FIFO with valid/ready backpressure.
// Ports:
//   clk, resetn                      clock, async active-low reset
//   req_valid/req_ready, req_write,  burst request (len = beats minus one)
//   req_addr, req_len
//   wr_valid/wr_ready, wr_data       store beats
//   wr_strb                          byte strobes (LS_MEM_RESP_BYTE_WE_EN only)
//   rd_valid/rd_ready, rd_data,      load beats, rd_last on final beat
//   rd_last
//   busy                             burst active or load data outstanding
//   mem_en, mem_we, mem_addr,        BRAM port (mem_we is per-byte when
//   mem_wdata, mem_rdata             LS_MEM_RESP_BYTE_WE_EN is defined)
// Build option: define LS_MEM_RESP_BYTE_WE_EN for byte-granular writes.
// ---------------------------------------------------------------------------
module ls_mem_responder
   import ls_mem_resp_pkg::*;
#(
   parameter int data_width = 64,
   parameter int addr_width = 10,
   parameter int rd_latency = 2
) (
   input  logic                    clk,
   input  logic                    resetn,
   input  logic                    req_valid,
   output logic                    req_ready,
   input  logic                    req_write,
   input  logic [addr_width-1:0]   req_addr,
   input  logic [LEN_W-1:0]        req_len,
   input  logic                    wr_valid,
   output logic                    wr_ready,
   input  logic [data_width-1:0]   wr_data,
`ifdef LS_MEM_RESP_BYTE_WE_EN
   input  logic [data_width/8-1:0] wr_strb,
`endif
   output logic                    rd_valid,
   input  logic                    rd_ready,
   output logic [data_width-1:0]   rd_data,
   output logic                    rd_last,
   output logic                    busy,
   output logic                    mem_en,
`ifdef LS_MEM_RESP_BYTE_WE_EN
   output logic [data_width/8-1:0] mem_we,
`else
   output logic                    mem_we,
`endif
   output logic [addr_width-1:0]   mem_addr,
   output logic [data_width-1:0]   mem_wdata,
   input  logic [data_width-1:0]   mem_rdata
);

   localparam int DEPTH = fifo_depth(rd_latency);
   localparam int CNT_W = $clog2(DEPTH + 1);
`ifdef LS_MEM_RESP_BYTE_WE_EN
   localparam int WE_W = data_width / 8;
`else
   localparam int WE_W = 1;
`endif

   state_e                  r_state;
   state_e                  w_state_nxt;
   logic [addr_width-1:0]   r_addr;
   logic [addr_width-1:0]   w_addr_nxt;
   logic [LEN_W-1:0]        r_rem;
   logic [LEN_W-1:0]        w_rem_nxt;
   logic                    w_accept;
   logic                    w_issue_rd;
   logic                    w_issue_last;
   logic [addr_width-1:0]   w_issue_addr;
   logic                    w_wr_beat;
   logic [WE_W-1:0]         w_wr_we;

   // Stage 0 of the read tag pipe lines up with the registered mem_en.
   logic                    r_iss_rd;
   logic                    r_iss_last;
   logic [rd_latency:1]     r_tv;
   logic [rd_latency:1]     r_tl;

   logic                    r_mem_en;
   logic [WE_W-1:0]         r_mem_we;
   logic [addr_width-1:0]   r_mem_addr;
   logic [data_width-1:0]   r_mem_wdata;
   logic                    r_busy;

   logic                    w_push;
   logic                    w_pop;
   logic [data_width:0]     w_head;
   logic [CNT_W-1:0]        w_fifo_cnt;
   logic [7:0]              w_inflight;
   logic [7:0]              w_pending;
   logic                    w_pipe_keep;
   logic                    w_credit_ok;
   logic                    w_fifo_nz_nxt;
   logic                    w_busy_nxt;

   assign req_ready = resetn & (r_state == ST_IDLE);
   assign wr_ready  = (r_state == ST_WRITE);
   assign w_accept  = req_valid & req_ready;
   assign w_pop     = rd_valid & rd_ready;
   assign w_push    = r_tv[rd_latency];

`ifdef LS_MEM_RESP_BYTE_WE_EN
   assign w_wr_we = wr_strb;
`else
   assign w_wr_we = 1'b1;
`endif

   // Count reads in flight; also note which will still be in flight next cycle.
   always_comb begin
      w_inflight  = {7'd0, r_iss_rd};
      w_pipe_keep = r_iss_rd;
      for (int k = 1; k <= rd_latency; k++) begin
         w_inflight = w_inflight + {7'd0, r_tv[k]};
      end
      for (int k = 1; k < rd_latency; k++) begin
         w_pipe_keep = w_pipe_keep | r_tv[k];
      end
   end

   // A beat popped this cycle frees its slot in time for a read issued now.
   assign w_pending   = 8'(w_fifo_cnt) + w_inflight - {7'd0, w_pop};
   assign w_credit_ok = (w_pending < 8'(DEPTH));

   // Burst FSM: issue reads under credit, accept store beats, track address.
   always_comb begin
      w_state_nxt  = r_state;
      w_addr_nxt   = r_addr;
      w_rem_nxt    = r_rem;
      w_issue_rd   = 1'b0;
      w_issue_last = 1'b0;
      w_issue_addr = r_addr;
      w_wr_beat    = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_accept) begin
               if (req_write) begin
                  w_state_nxt = ST_WRITE;
                  w_addr_nxt  = req_addr;
                  w_rem_nxt   = req_len;
               end else if (w_credit_ok) begin
                  // First read leaves in the acceptance cycle.
                  w_issue_rd   = 1'b1;
                  w_issue_addr = req_addr;
                  w_issue_last = (req_len == LEN_W'(0));
                  w_addr_nxt   = req_addr + addr_width'(1);
                  w_rem_nxt    = req_len - LEN_W'(1);
                  w_state_nxt  = (req_len == LEN_W'(0)) ? ST_IDLE : ST_READ;
               end else begin
                  w_state_nxt = ST_READ;
                  w_addr_nxt  = req_addr;
                  w_rem_nxt   = req_len;
               end
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_READ: begin
            if (w_credit_ok) begin
               w_issue_rd   = 1'b1;
               w_issue_addr = r_addr;
               w_issue_last = (r_rem == LEN_W'(0));
               w_addr_nxt   = r_addr + addr_width'(1);
               w_rem_nxt    = r_rem - LEN_W'(1);
               w_state_nxt  = (r_rem == LEN_W'(0)) ? ST_IDLE : ST_READ;
            end else begin
               w_state_nxt = ST_READ;
            end
         end
         ST_WRITE: begin
            if (wr_valid) begin
               w_wr_beat   = 1'b1;
               w_addr_nxt  = r_addr + addr_width'(1);
               w_rem_nxt   = r_rem - LEN_W'(1);
               w_state_nxt = (r_rem == LEN_W'(0)) ? ST_IDLE : ST_WRITE;
            end else begin
               w_state_nxt = ST_WRITE;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // Busy is registered, so derive it from next-cycle state, pipe and FIFO.
   always_comb begin
      w_fifo_nz_nxt = w_push
                    | (w_fifo_cnt > CNT_W'(1))
                    | ((w_fifo_cnt == CNT_W'(1)) & ~w_pop);
      w_busy_nxt    = (w_state_nxt != ST_IDLE) | w_issue_rd | w_pipe_keep
                    | w_fifo_nz_nxt;
   end

   // FSM state, burst address/count and registered BRAM port.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state     <= ST_IDLE;
         r_addr      <= {addr_width{1'b0}};
         r_rem       <= LEN_W'(0);
         r_mem_en    <= 1'b0;
         r_mem_we    <= {WE_W{1'b0}};
         r_mem_addr  <= {addr_width{1'b0}};
         r_mem_wdata <= {data_width{1'b0}};
         r_busy      <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_addr   <= w_addr_nxt;
         r_rem    <= w_rem_nxt;
         r_mem_en <= w_issue_rd | w_wr_beat;
         r_busy   <= w_busy_nxt;
         if (w_issue_rd) begin
            r_mem_addr <= w_issue_addr;
            r_mem_we   <= {WE_W{1'b0}};
         end else if (w_wr_beat) begin
            r_mem_addr  <= r_addr;
            r_mem_wdata <= wr_data;
            r_mem_we    <= w_wr_we;
         end else begin
            r_mem_we <= {WE_W{1'b0}};
         end
      end
   end

   // Read tag pipe: marks which BRAM output cycles carry load data and last.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_iss_rd   <= 1'b0;
         r_iss_last <= 1'b0;
         r_tv       <= '0;
         r_tl       <= '0;
      end else begin
         r_iss_rd   <= w_issue_rd;
         r_iss_last <= w_issue_last;
         r_tv[1]    <= r_iss_rd;
         r_tl[1]    <= r_iss_last;
         for (int k = 2; k <= rd_latency; k++) begin
            r_tv[k] <= r_tv[k-1];
            r_tl[k] <= r_tl[k-1];
         end
      end
   end

   ls_mem_resp_fifo #(
      .width (data_width + 1),
      .depth (DEPTH)
   ) u_fifo (
      .clk    (clk),
      .resetn (resetn),
      .push   (w_push),
      .din    ({r_tl[rd_latency], mem_rdata}),
      .pop    (w_pop),
      .valid  (rd_valid),
      .dout   (w_head),
      .count  (w_fifo_cnt)
   );

   assign rd_last   = w_head[data_width];
   assign rd_data   = w_head[data_width-1:0];
   assign busy      = r_busy;
   assign mem_en    = r_mem_en;
   assign mem_we    = r_mem_we;
   assign mem_addr  = r_mem_addr;
   assign mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_ls_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_ls_mem_responder
// Directed bench for ls_mem_responder with a behavioural 2-cycle BRAM.
// Honours LS_MEM_RESP_BYTE_WE_EN for the byte-strobe scenario.
// ---------------------------------------------------------------------------
module tb_ls_mem_responder;

   logic        clk;
   logic        resetn;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [9:0]  req_addr;
   logic [3:0]  req_len;
   logic        wr_valid;
   logic        wr_ready;
   logic [63:0] wr_data;
`ifdef LS_MEM_RESP_BYTE_WE_EN
   logic [7:0]  wr_strb;
   logic [7:0]  mem_we;
   localparam logic [63:0] WE_ALL = 64'hFF;
`else
   logic        mem_we;
   localparam logic [63:0] WE_ALL = 64'h1;
`endif
   logic        rd_valid;
   logic        rd_ready;
   logic [63:0] rd_data;
   logic        rd_last;
   logic        busy;
   logic        mem_en;
   logic [9:0]  mem_addr;
   logic [63:0] mem_wdata;
   logic [63:0] mem_rdata;

   int          checks;
   int          failures;
   int          beats_got;
   logic [63:0] exp_d [16];
   logic [63:0] wd [4];

   ls_mem_responder #(
      .data_width (64),
      .addr_width (10),
      .rd_latency (2)
   ) dut (
      .clk       (clk),
      .resetn    (resetn),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_write (req_write),
      .req_addr  (req_addr),
      .req_len   (req_len),
      .wr_valid  (wr_valid),
      .wr_ready  (wr_ready),
      .wr_data   (wr_data),
`ifdef LS_MEM_RESP_BYTE_WE_EN
      .wr_strb   (wr_strb),
`endif
      .rd_valid  (rd_valid),
      .rd_ready  (rd_ready),
      .rd_data   (rd_data),
      .rd_last   (rd_last),
      .busy      (busy),
      .mem_en    (mem_en),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Initial BRAM content: a recognisable tag plus the word address.
   function automatic logic [63:0] pat(input logic [9:0] a);
      return {16'hA5C3, 38'd0, a};
   endfunction

   // Behavioural BRAM: 2-cycle read latency, written words override pat().
   bit   [1023:0] wr_seen;
   logic [63:0]   wmem [1024];
   logic [63:0]   bram_p1;
   logic [63:0]   bram_p2;

   function automatic logic [63:0] rd_word(input logic [9:0] a);
      return wr_seen[a] ? wmem[a] : pat(a);
   endfunction

   always @(posedge clk) begin
      logic [63:0] cur;
      cur = rd_word(mem_addr);
      if (mem_en && (mem_we == '0)) bram_p1 <= cur;
      else                          bram_p1 <= 64'hDEAD_DEAD_DEAD_DEAD;
      bram_p2 <= bram_p1;
      if (mem_en && (mem_we != '0)) begin
         for (int b = 0; b < 8; b++) begin
`ifdef LS_MEM_RESP_BYTE_WE_EN
            if (mem_we[b]) cur[b*8 +: 8] = mem_wdata[b*8 +: 8];
`else
            cur[b*8 +: 8] = mem_wdata[b*8 +: 8];
`endif
         end
         wmem[mem_addr]    <= cur;
         wr_seen[mem_addr] <= 1'b1;
      end
   end
   assign mem_rdata = bram_p2;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Present a request at a falling edge and hold it until it is taken.
   task automatic send_req(input logic w, input logic [9:0] a, input logic [3:0] l);
      int n;
      req_valid = 1'b1;
      req_write = w;
      req_addr  = a;
      req_len   = l;
      n = 0;
      while (!req_ready && n < 60) begin
         @(negedge clk);
         n++;
      end
      chk("req_accept_wait", 64'(n < 60), 64'd1);
      @(negedge clk);
      req_valid = 1'b0;
   endtask

   // Drive n store beats from wd[] and check the BRAM write one cycle later.
   task automatic write_beats(input int n, input logic [9:0] base, input logic [63:0] exp_we);
      for (int i = 0; i < n; i++) begin
         int k;
         logic [9:0] ea;
         wr_valid = 1'b1;
         wr_data  = wd[i];
         k = 0;
         while (!wr_ready && k < 60) begin
            @(negedge clk);
            k++;
         end
         chk("wr_ready_wait", 64'(k < 60), 64'd1);
         @(negedge clk);
         if (i == n - 1) wr_valid = 1'b0;
         ea = base + 10'(i);
         chk($sformatf("wr%0d_en", i),    64'(mem_en),    64'd1);
         chk($sformatf("wr%0d_we", i),    64'(mem_we),    exp_we);
         chk($sformatf("wr%0d_addr", i),  64'(mem_addr),  64'(ea));
         chk($sformatf("wr%0d_wdata", i), mem_wdata,      wd[i]);
      end
   endtask

   // Consume n load beats (mode 1: rd_ready high one cycle in three).
   task automatic collect(input int n, input int mode, input string tag);
      int cyc;
      int max_occ;
      beats_got = 0;
      cyc       = 0;
      max_occ   = 0;
      while (beats_got < n && cyc < 400) begin
         @(negedge clk);
         cyc++;
         rd_ready = (mode == 0) ? 1'b1 : ((cyc % 3) == 0);
         if (int'(dut.u_fifo.count) > max_occ) max_occ = int'(dut.u_fifo.count);
         if (rd_valid && rd_ready) begin
            chk($sformatf("%s_data%0d", tag, beats_got), rd_data, exp_d[beats_got]);
            chk($sformatf("%s_last%0d", tag, beats_got), 64'(rd_last), 64'(beats_got == n - 1));
            beats_got++;
         end
      end
      rd_ready = 1'b1;
      chk({tag, "_beats"}, 64'(beats_got), 64'(n));
      chk({tag, "_occ_max"}, 64'(max_occ <= 4), 64'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

   initial begin
      checks    = 0;
      failures  = 0;
      resetn    = 1'b0;
      req_valid = 1'b0;
      req_write = 1'b0;
      req_addr  = 10'd0;
      req_len   = 4'd0;
      wr_valid  = 1'b0;
      wr_data   = 64'd0;
`ifdef LS_MEM_RESP_BYTE_WE_EN
      wr_strb   = 8'hFF;
`endif
      rd_ready  = 1'b1;

      // Reset values.
      repeat (3) @(negedge clk);
      chk("rst_req_ready", 64'(req_ready), 64'd0);
      chk("rst_wr_ready",  64'(wr_ready),  64'd0);
      chk("rst_rd_valid",  64'(rd_valid),  64'd0);
      chk("rst_busy",      64'(busy),      64'd0);
      chk("rst_mem_en",    64'(mem_en),    64'd0);
      chk("rst_mem_addr",  64'(mem_addr),  64'd0);
      chk("rst_rd_data",   rd_data,        64'd0);
      resetn = 1'b1;
      @(negedge clk);
      chk("post_rst_req_ready", 64'(req_ready), 64'd1);

      // Load 0x010 len 3: cycle-exact issue and return timing.
      req_valid = 1'b1;
      req_write = 1'b0;
      req_addr  = 10'h010;
      req_len   = 4'd3;
      @(negedge clk);
      req_valid = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         if (k > 1) @(negedge clk);
         chk($sformatf("t1_mem_en_c%0d", k),    64'(mem_en),    64'(k <= 4));
         chk($sformatf("t1_rd_valid_c%0d", k),  64'(rd_valid),  64'(k >= 4 && k <= 7));
         chk($sformatf("t1_req_ready_c%0d", k), 64'(req_ready), 64'(k >= 4));
         chk($sformatf("t1_busy_c%0d", k),      64'(busy),      64'(k <= 7));
         if (k <= 4) begin
            chk($sformatf("t1_mem_addr_c%0d", k), 64'(mem_addr), 64'(10'h010 + 10'(k - 1)));
            chk($sformatf("t1_mem_we_c%0d", k),   64'(mem_we),   64'd0);
         end
         if (k >= 4 && k <= 7) begin
            chk($sformatf("t1_rd_data_c%0d", k), rd_data, pat(10'h010 + 10'(k - 4)));
            chk($sformatf("t1_rd_last_c%0d", k), 64'(rd_last), 64'(k == 7));
         end
      end

      // Store 0x3FE len 3 wraps to 0x000/0x001.
      wd[0] = 64'h1111_2222_3333_4444;
      wd[1] = 64'h5555_6666_7777_8888;
      wd[2] = 64'h9999_AAAA_BBBB_CCCC;
      wd[3] = 64'hDDDD_EEEE_FFFF_0123;
      @(negedge clk);
      send_req(1'b1, 10'h3FE, 4'd3);
      chk("t2_wr_ready", 64'(wr_ready), 64'd1);
      write_beats(4, 10'h3FE, WE_ALL);
      chk("t2_idle_req_ready", 64'(req_ready), 64'd1);
      chk("t2_idle_wr_ready",  64'(wr_ready),  64'd0);
      @(negedge clk);
      chk("t2_mem_en_off", 64'(mem_en), 64'd0);

      // Read the wrapped store back.
      exp_d[0] = 64'h1111_2222_3333_4444;
      exp_d[1] = 64'h5555_6666_7777_8888;
      exp_d[2] = 64'h9999_AAAA_BBBB_CCCC;
      exp_d[3] = 64'hDDDD_EEEE_FFFF_0123;
      fork
         collect(4, 0, "t2rb");
         send_req(1'b0, 10'h3FE, 4'd3);
      join

      // Long load under heavy backpressure.
      for (int i = 0; i < 16; i++) exp_d[i] = pat(10'h100 + 10'(i));
      fork
         collect(16, 1, "t3");
         send_req(1'b0, 10'h100, 4'd15);
      join

      // Store accepted while an earlier load is still draining.
      for (int i = 0; i < 8; i++) exp_d[i] = pat(10'h200 + 10'(i));
      wd[0] = 64'hE0E0_0000_0000_0000;
      wd[1] = 64'hE1E1_0000_0000_0001;
      wd[2] = 64'hE2E2_0000_0000_0002;
      wd[3] = 64'hE3E3_0000_0000_0003;
      fork
         collect(8, 0, "t4");
         begin
            int n;
            send_req(1'b0, 10'h200, 4'd7);
            n = 0;
            while (!req_ready && n < 60) begin
               @(negedge clk);
               n++;
            end
            chk("t4_ready_wait", 64'(n < 60), 64'd1);
            chk("t4_busy_at_store", 64'(busy), 64'd1);
            chk("t4_draining", 64'(beats_got < 8), 64'd1);
            send_req(1'b1, 10'h200, 4'd3);
            write_beats(4, 10'h200, WE_ALL);
         end
      join
      exp_d[0] = 64'hE0E0_0000_0000_0000;
      fork
         collect(1, 0, "t4rb");
         send_req(1'b0, 10'h200, 4'd0);
      join

      // Reset in the middle of an 8-beat load.
      @(negedge clk);
      send_req(1'b0, 10'h300, 4'd7);
      repeat (5) @(negedge clk);
      chk("t5_beat3_present", 64'(rd_valid), 64'd1);
      chk("t5_beat3_data", rd_data, pat(10'h302));
      resetn = 1'b0;
      #1;
      chk("t5_rst_rd_valid",  64'(rd_valid),  64'd0);
      chk("t5_rst_mem_en",    64'(mem_en),    64'd0);
      chk("t5_rst_busy",      64'(busy),      64'd0);
      chk("t5_rst_req_ready", 64'(req_ready), 64'd0);
      @(negedge clk);
      resetn = 1'b1;
      #1;
      chk("t5_rel_req_ready", 64'(req_ready), 64'd1);
      @(negedge clk);
      exp_d[0] = pat(10'h040);
      exp_d[1] = pat(10'h041);
      fork
         collect(2, 0, "t5");
         send_req(1'b0, 10'h040, 4'd1);
      join
      repeat (3) @(negedge clk);
      chk("t5_no_stale_valid", 64'(rd_valid), 64'd0);
      chk("t5_idle_busy",      64'(busy),     64'd0);

`ifdef LS_MEM_RESP_BYTE_WE_EN
      // Byte strobes reach mem_we on writes; reads drive zero.
      begin
         logic [63:0] base;
         wd[0]   = 64'hFFFF_FFFF_FFFF_FFFF;
         wr_strb = 8'h0F;
         send_req(1'b1, 10'h050, 4'd0);
         write_beats(1, 10'h050, 64'h0F);
         wr_strb = 8'hFF;
         base     = pat(10'h050);
         exp_d[0] = {base[63:32], 32'hFFFF_FFFF};
         fork
            collect(1, 0, "t6");
            begin
               send_req(1'b0, 10'h050, 4'd0);
               chk("t6_rd_mem_en", 64'(mem_en), 64'd1);
               chk("t6_rd_mem_we", 64'(mem_we), 64'd0);
            end
         join
      end
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
